// File: rtl/t05_pack_sched.sv
// t05_pack_sched: chunk-to-byte sequencer for the 7-to-8-bit packer with valid/ready source and sink.
// Define T05_PACK_LEN_TRAILER_EN to append a valid-bit-count trailer byte to every stream.
module t05_pack_sched #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [CNT_W-1:0] total_chunks,
    output logic             busy,
    output logic             done,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [6:0]       src_data,
    output logic             pk_en,
    output logic             pk_pulse,
    output logic [6:0]       pk_in,
    output logic             pk_rst_n,
    input  logic [7:0]       pk_out,
    input  logic             pk_out_valid,
    input  logic [6:0]       pk_leftover_data,
    input  logic [2:0]       pk_leftover_count,
    output logic             wr_valid,
    input  logic             wr_ready,
    output logic [7:0]       wr_data,
    output logic             wr_last,
    output logic [CNT_W-1:0] bytes_out
);
`ifdef T05_PACK_LEN_TRAILER_EN
    localparam bit TRL = 1'b1;
`else
    localparam bit TRL = 1'b0;
`endif
    typedef enum logic [2:0] {IDLE, FEED, WAIT, OUT, FLUSH, CLR, DONE, TRAIL} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d, bytes_q, bytes_d;
    logic [7:0]       data_q, data_d, flush_byte;
    logic [3:0]       bits_q, bits_d;
    logic             pk_rst_n_q;
    // residual bits move to the MSBs, zero padding below
    assign flush_byte = {pk_leftover_data, 1'b0} << (3'd7 - pk_leftover_count);
    assign pk_en      = 1'b1;
    assign pk_in      = src_data;
    assign pk_rst_n   = pk_rst_n_q;
    assign busy       = state_q != IDLE;
    assign done       = state_q == DONE;
    assign bytes_out  = bytes_q;
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        bytes_d   = bytes_q;
        data_d    = data_q;
        bits_d    = bits_q;
        src_ready = 1'b0;
        pk_pulse  = 1'b0;
        wr_valid  = 1'b0;
        wr_last   = 1'b0;
        wr_data   = data_q;
        case (state_q)
            IDLE: if (start) begin
                rem_d   = total_chunks;
                bytes_d = '0;
                bits_d  = '0;
                state_d = (total_chunks == '0) ? (TRL ? TRAIL : DONE) : FEED;
            end
            FEED: begin
                src_ready = 1'b1;
                if (src_valid) begin
                    pk_pulse = 1'b1;
                    rem_d    = rem_q - CNT_W'(1);
                    state_d  = WAIT;
                end
            end
            WAIT: if (pk_out_valid) begin
                data_d  = pk_out;
                state_d = OUT;
            end else begin
                state_d = (rem_q != '0) ? FEED : FLUSH;
            end
            OUT: begin
                wr_valid = 1'b1;
                wr_last  = !TRL && rem_q == '0 && pk_leftover_count == 3'd0;
                if (wr_ready) begin
                    bytes_d = bytes_q + CNT_W'(1);
                    bits_d  = 4'd8;
                    state_d = (rem_q != '0) ? FEED : (pk_leftover_count != 3'd0) ? FLUSH : CLR;
                end
            end
            FLUSH: begin
                wr_data = flush_byte;
                if (pk_leftover_count == 3'd0) begin
                    state_d = CLR;
                end else begin
                    wr_valid = 1'b1;
                    wr_last  = !TRL;
                    if (wr_ready) begin
                        bytes_d = bytes_q + CNT_W'(1);
                        bits_d  = {1'b0, pk_leftover_count};
                        state_d = CLR;
                    end
                end
            end
            CLR: state_d = TRL ? TRAIL : DONE;
            TRAIL: begin
                wr_valid = 1'b1;
                wr_last  = 1'b1;
                wr_data  = {4'd0, bits_q};
                if (wr_ready) begin
                    bytes_d = bytes_q + CNT_W'(1);
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            bytes_q    <= '0;
            data_q     <= '0;
            bits_q     <= '0;
            pk_rst_n_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            bytes_q    <= bytes_d;
            data_q     <= data_d;
            bits_q     <= bits_d;
            pk_rst_n_q <= state_d != CLR;
        end
    end
endmodule

// File: tb/tb_t05_pack_sched.sv
// tb_t05_pack_sched: directed streams against a behavioural packer; sink bytes checked by a scoreboard.
module tb_t05_pack_sched;
`ifdef T05_PACK_LEN_TRAILER_EN
    localparam int TRL = 1;
`else
    localparam int TRL = 0;
`endif
    logic        clk = 1'b0, nrst, start, src_valid, wr_ready;
    logic [15:0] total_chunks, bytes_out;
    logic [6:0]  src_data, pk_in, pk_leftover_data;
    logic [2:0]  pk_leftover_count;
    logic [7:0]  pk_out, wr_data;
    logic        busy, done, src_ready, pk_en, pk_pulse, pk_rst_n, pk_out_valid, wr_valid, wr_last;
    int n_chk = 0, n_fail = 0, done_cnt = 0, rst_cnt = 0;
    typedef struct packed {logic [7:0] d; logic l;} exp_t;
    exp_t q[$];
    exp_t e;
    t05_pack_sched #(.CNT_W(16)) dut (
        .clk(clk), .nrst(nrst), .start(start), .total_chunks(total_chunks), .busy(busy), .done(done),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data), .pk_en(pk_en),
        .pk_pulse(pk_pulse), .pk_in(pk_in), .pk_rst_n(pk_rst_n), .pk_out(pk_out),
        .pk_out_valid(pk_out_valid), .pk_leftover_data(pk_leftover_data),
        .pk_leftover_count(pk_leftover_count), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_last(wr_last), .bytes_out(bytes_out)
    );
    always #5 clk = ~clk;
    // behavioural packer: residual bits LSB-aligned, a byte leaves once 8 bits have accumulated
    logic        pk_nrst;
    logic [13:0] v;
    logic [7:0]  nb;
    logic [6:0]  nlo;
    logic [2:0]  nlc;
    assign pk_nrst = nrst & pk_rst_n;
    always_comb begin
        v   = {pk_leftover_data, pk_in};
        nb  = 8'(v >> (pk_leftover_count - 3'd1));
        nlc = (pk_leftover_count == 3'd0) ? 3'd7 : pk_leftover_count - 3'd1;
        nlo = (pk_leftover_count == 3'd0) ? pk_in : pk_in & ((7'd1 << nlc) - 7'd1);
    end
    always_ff @(posedge clk or negedge pk_nrst) begin
        if (!pk_nrst) begin
            pk_leftover_data  <= '0;
            pk_leftover_count <= '0;
            pk_out            <= '0;
            pk_out_valid      <= 1'b0;
        end else begin
            pk_out_valid <= 1'b0;
            if (pk_pulse && pk_en) begin
                pk_out_valid      <= pk_leftover_count != 3'd0;
                pk_out            <= nb;
                pk_leftover_data  <= nlo;
                pk_leftover_count <= nlc;
            end
        end
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask
    always @(negedge clk) begin
        if (nrst && wr_valid && wr_ready) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL wr_unexpected: got byte %02h last %0b, required no byte", wr_data, wr_last);
            end else begin
                e = q.pop_front();
                chk("wr_data", {24'd0, wr_data}, {24'd0, e.d});
                chk("wr_last", {31'd0, wr_last}, {31'd0, e.l});
            end
        end
        if (done) done_cnt++;
        if (nrst && !pk_rst_n) rst_cnt++;
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic push(input logic [7:0] d, input logic l);
        q.push_back('{d: d, l: l});
    endtask
    task automatic push_last(input logic [7:0] d, input logic [7:0] nbits);
        if (TRL != 0) begin
            push(d, 1'b0);
            push(nbits, 1'b1);
        end else push(d, 1'b1);
    endtask
    task automatic begin_stream(input int n);
        total_chunks = 16'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    task automatic feed(input logic [6:0] c);
        int t = 0;
        src_valid = 1'b1;
        src_data  = c;
        @(negedge clk);
        while (!src_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("src_ready", {31'd0, src_ready}, 1);
        chk("pk_pulse", {31'd0, pk_pulse}, 1);
        chk("pk_in", {25'd0, pk_in}, {25'd0, c});
        @(posedge clk);
        #1 src_valid = 1'b0;
    endtask
    task automatic end_stream(input string nm, input int d0, input int r0, input int exp_bytes,
                              input int exp_rst, output int t);
        t = 0;
        while (done_cnt == d0 && t < 300) begin
            tick();
            t++;
        end
        chk({nm, "_done"}, done_cnt - d0, 1);
        chk({nm, "_bytes_out"}, {16'd0, bytes_out}, exp_bytes);
        chk({nm, "_pk_rst_cycles"}, rst_cnt - r0, exp_rst);
        chk({nm, "_queue_left"}, q.size(), 0);
        tick();
        chk({nm, "_idle"}, {31'd0, busy}, 0);
    endtask
    task automatic run_one(input string nm);
        int d0 = done_cnt, r0 = rst_cnt, t;
        push_last(8'hFE, 8'd7);
        begin_stream(1);
        feed(7'h7F);
        end_stream(nm, d0, r0, 1 + TRL, 1, t);
    endtask
    initial begin
        int d0, r0, t;
        logic [7:0] c_bytes [7];
        c_bytes = '{8'hAB, 8'h56, 8'hAD, 8'h5A, 8'hB5, 8'h6A, 8'hD5};
        nrst = 1'b0; start = 1'b0; src_valid = 1'b0; wr_ready = 1'b1;
        total_chunks = '0; src_data = '0;
        repeat (3) tick();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_src_ready", {31'd0, src_ready}, 0);
        chk("rst_wr_valid", {31'd0, wr_valid}, 0);
        chk("rst_wr_data", {24'd0, wr_data}, 0);
        chk("rst_pk_rst_n", {31'd0, pk_rst_n}, 1);
        chk("rst_pk_en", {31'd0, pk_en}, 1);
        nrst = 1'b1;
        tick();
        run_one("single");
        d0 = done_cnt; r0 = rst_cnt;
        push(8'hFE, 1'b0);
        push_last(8'h00, 8'd6);
        begin_stream(2);
        feed(7'h7F);
        feed(7'h00);
        end_stream("two", d0, r0, 2 + TRL, 1, t);
        d0 = done_cnt; r0 = rst_cnt;
        for (int i = 0; i < 6; i++) push(c_bytes[i], 1'b0);
        push_last(c_bytes[6], 8'd8);
        begin_stream(8);
        for (int i = 0; i < 8; i++) feed(7'h55);
        end_stream("eight", d0, r0, 7 + TRL, 1, t);
        d0 = done_cnt; r0 = rst_cnt;
        wr_ready = 1'b0;
        push_last(8'hFE, 8'd7);
        begin_stream(1);
        feed(7'h7F);
        t = 0;
        while (!wr_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_wr_valid", {31'd0, wr_valid}, 1);
            chk("bp_wr_data", {24'd0, wr_data}, 32'hFE);
            chk("bp_src_ready", {31'd0, src_ready}, 0);
            chk("bp_pk_pulse", {31'd0, pk_pulse}, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 wr_ready = 1'b1;
        end_stream("backpressure", d0, r0, 1 + TRL, 1, t);
        d0 = done_cnt; r0 = rst_cnt;
        if (TRL != 0) push(8'h00, 1'b1);
        begin_stream(0);
        end_stream("empty", d0, r0, TRL, 0, t);
        chk("empty_latency", t, 1 + TRL);
        d0 = done_cnt;
        push(8'hAB, 1'b0);
        push(8'h56, 1'b0);
        begin_stream(8);
        for (int i = 0; i < 3; i++) feed(7'h55);
        repeat (4) tick();
        chk("abort_queue", q.size(), 0);
        chk("abort_bytes_pre", {16'd0, bytes_out}, 2);
        nrst = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_src_ready", {31'd0, src_ready}, 0);
        chk("abort_wr_valid", {31'd0, wr_valid}, 0);
        chk("abort_wr_last", {31'd0, wr_last}, 0);
        chk("abort_bytes_out", {16'd0, bytes_out}, 0);
        chk("abort_pk_rst_n", {31'd0, pk_rst_n}, 1);
        chk("abort_pk_left", {29'd0, pk_leftover_count}, 0);
        repeat (2) tick();
        nrst = 1'b1;
        tick();
        chk("abort_no_done", done_cnt - d0, 0);
        run_one("after_abort");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
